// File: rtl/register_file_write_arbiter.sv
// Write-port owner for the register file: round-robin arbitration of the
// write requesters plus a bulk-clear sequencer, since the file has no reset.
module register_file_write_arbiter #(
    parameter int NUMBER_OF_REGISTERS = 256,
    parameter int NUM_REQUESTERS = 4,
    parameter bit CLEAR_ON_RESET = 1'b1,
    localparam int ADDR_W = $clog2(NUMBER_OF_REGISTERS),
    localparam int ID_W = $clog2(NUM_REQUESTERS)
) (
    input  logic                             clock_in,
    input  logic                             reset_n_in,
    input  logic                             clear_start_in,
    output logic                             clear_busy_out,
    input  logic [NUM_REQUESTERS-1:0]        req_valid_in,
    output logic [NUM_REQUESTERS-1:0]        req_ready_out,
    input  logic [NUM_REQUESTERS*ADDR_W-1:0] req_addr_in,
    input  logic [NUM_REQUESTERS*8-1:0]      req_data_in,
    output logic [ID_W-1:0]                  grant_id_out,
    output logic                             rf_write_enable_out,
    output logic [ADDR_W-1:0]                rf_write_address_out,
    output logic [7:0]                       rf_write_data_out
);

    typedef enum logic {
        RUN,
        CLEAR
    } state_t;

    localparam state_t RESET_STATE = CLEAR_ON_RESET ? CLEAR : RUN;
    localparam logic [ADDR_W:0] LAST_CNT = (ADDR_W+1)'(NUMBER_OF_REGISTERS - 1);
    localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQUESTERS - 1);
    localparam logic [ID_W:0] NUM_WIDE = (ID_W+1)'(NUM_REQUESTERS);

    state_t            state;
    state_t            state_next;
    logic [ID_W-1:0]   rr_ptr;
    logic [ADDR_W:0]   clear_cnt;

    logic              found;
    logic [ID_W-1:0]   winner;
    logic [ID_W:0]     probe;
    logic [ID_W-1:0]   cand;
    logic              grant;
    logic [ID_W-1:0]   ptr_next;
    logic [ADDR_W-1:0] win_addr;
    logic [7:0]        win_data;

    // Rotating priority search starting at rr_ptr.
    always_comb begin
        found = 1'b0;
        winner = '0;
        probe = '0;
        cand = '0;
        for (int i = 0; i < NUM_REQUESTERS; i++) begin
            probe = {1'b0, rr_ptr} + (ID_W+1)'(i);
            if (probe >= NUM_WIDE) begin
                probe = probe - NUM_WIDE;
            end
            cand = probe[ID_W-1:0];
            if (!found && req_valid_in[cand]) begin
                found = 1'b1;
                winner = cand;
            end
        end
    end

    always_comb begin
        grant = found && (state == RUN) && reset_n_in;
        req_ready_out = '0;
        grant_id_out = '0;
        if (grant) begin
            req_ready_out[winner] = 1'b1;
            grant_id_out = winner;
        end
        ptr_next = (winner == LAST_ID) ? '0 : winner + 1'b1;
        win_addr = req_addr_in[int'(winner)*ADDR_W +: ADDR_W];
        win_data = req_data_in[int'(winner)*8 +: 8];
    end

    assign clear_busy_out = (state == CLEAR);

    always_comb begin
        state_next = state;
        unique case (state)
            RUN: begin
                if (clear_start_in) begin
                    state_next = CLEAR;
                end
            end
            CLEAR: begin
                if (clear_cnt == LAST_CNT) begin
                    state_next = RUN;
                end
            end
            default: state_next = RESET_STATE;
        endcase
    end

    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state <= RESET_STATE;
            rr_ptr <= '0;
            clear_cnt <= '0;
            rf_write_enable_out <= 1'b0;
            rf_write_address_out <= '0;
            rf_write_data_out <= '0;
        end else begin
            state <= state_next;
            unique case (state)
                CLEAR: begin
                    rf_write_enable_out <= 1'b1;
                    rf_write_address_out <= clear_cnt[ADDR_W-1:0];
                    rf_write_data_out <= '0;
                    clear_cnt <= clear_cnt + 1'b1;
                end
                RUN: begin
                    if (grant) begin
                        rf_write_enable_out <= 1'b1;
                        rf_write_address_out <= win_addr;
                        rf_write_data_out <= win_data;
                        rr_ptr <= ptr_next;
                    end else begin
                        rf_write_enable_out <= 1'b0;
                    end
                    if (clear_start_in) begin
                        clear_cnt <= '0;
                    end
                end
                default: rf_write_enable_out <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_register_file_write_arbiter.sv
// Bench for register_file_write_arbiter: directed scenarios plus random
// traffic against a queue-based reference model of the write port.
module tb_register_file_write_arbiter;

    localparam int NR = 256;
    localparam int NQ = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear_start = 1'b0;
    logic [3:0]  valid = '0;
    logic [31:0] addr = '0;
    logic [31:0] data = '0;
    logic        busy;
    logic [3:0]  ready;
    logic [1:0]  gid;
    logic        we;
    logic [7:0]  waddr;
    logic [7:0]  wdata;

    register_file_write_arbiter #(
        .NUMBER_OF_REGISTERS(NR),
        .NUM_REQUESTERS(NQ),
        .CLEAR_ON_RESET(1'b1)
    ) dut (
        .clock_in(clk),
        .reset_n_in(rst_n),
        .clear_start_in(clear_start),
        .clear_busy_out(busy),
        .req_valid_in(valid),
        .req_ready_out(ready),
        .req_addr_in(addr),
        .req_data_in(data),
        .grant_id_out(gid),
        .rf_write_enable_out(we),
        .rf_write_address_out(waddr),
        .rf_write_data_out(wdata)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    bit m_busy;
    int m_q[$];
    int m_ptr;
    bit m_we;
    int m_addr;
    int m_data;
    int obs_grant;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(logic [3:0] v, int p);
        for (int k = 0; k < NQ; k++) begin
            if (v[(p + k) % NQ]) return (p + k) % NQ;
        end
        return -1;
    endfunction

    task automatic fill_clear();
        m_busy = 1'b1;
        m_q.delete();
        for (int i = 0; i < NR; i++) m_q.push_back(i);
    endtask

    task automatic model_reset();
        fill_clear();
        m_ptr = 0;
        m_we = 1'b0;
        m_addr = 0;
        m_data = 0;
    endtask

    task automatic set_req(int j, logic [7:0] a, logic [7:0] d);
        addr[j*8 +: 8] = a;
        data[j*8 +: 8] = d;
    endtask

    task automatic cycle();
        int w;
        #1;
        w = m_busy ? -1 : pick(valid, m_ptr);
        check("ready", {28'd0, ready}, (w < 0) ? 0 : (1 << w));
        if (w >= 0) check("grant_id", {30'd0, gid}, w);
        obs_grant = (ready != 0) ? int'(gid) : -1;
        @(posedge clk);
        if (m_busy) begin
            m_we = 1'b1;
            m_addr = m_q.pop_front();
            m_data = 0;
            if (m_q.size() == 0) m_busy = 1'b0;
        end else begin
            if (w >= 0) begin
                m_we = 1'b1;
                m_addr = int'(addr[w*8 +: 8]);
                m_data = int'(data[w*8 +: 8]);
                m_ptr = (w + 1) % NQ;
            end else begin
                m_we = 1'b0;
            end
            if (clear_start) fill_clear();
        end
        #1;
        check("we", {31'd0, we}, {31'd0, m_we});
        check("waddr", {24'd0, waddr}, m_addr);
        check("wdata", {24'd0, wdata}, m_data);
        check("busy", {31'd0, busy}, {31'd0, m_busy});
    endtask

    initial begin
        int g;
        model_reset();
        valid = 4'hF;
        #12;
        check("rst_we", {31'd0, we}, 0);
        check("rst_waddr", {24'd0, waddr}, 0);
        check("rst_wdata", {24'd0, wdata}, 0);
        check("rst_busy", {31'd0, busy}, 1);
        check("rst_ready", {28'd0, ready}, 0);
        check("rst_gid", {30'd0, gid}, 0);
        rst_n = 1'b1;

        // 1: power-on clear with all requesters knocking
        for (int i = 0; i < NR; i++) begin
            cycle();
            check("clr_addr", {23'd0, we, waddr}, {23'd0, 1'b1, i[7:0]});
        end
        check("clr_done", {31'd0, busy}, 0);

        // 2: single requester
        valid = 4'b0010;
        set_req(1, 8'h10, 8'hAB);
        cycle();
        check("t2_grant", obs_grant, 1);
        check("t2_write", {15'd0, we, waddr, wdata}, {15'd0, 1'b1, 8'h10, 8'hAB});

        // 3: all four contend, starting from pointer 0
        valid = 4'b1000;
        cycle();
        valid = 4'hF;
        for (int j = 0; j < NQ; j++) set_req(j, 8'(8'h20 + j), 8'(8'h30 + j));
        for (int k = 0; k < 8; k++) begin
            cycle();
            check("t3_grant", obs_grant, k % NQ);
            check("t3_addr", {24'd0, waddr}, 32'h20 + (k % NQ));
            check("t3_data", {24'd0, wdata}, 32'h30 + (k % NQ));
        end

        // 4: requesters 0 and 2 after a grant to 2
        valid = 4'b0100;
        cycle();
        check("t4_pre", obs_grant, 2);
        valid = 4'b0101;
        cycle();
        check("t4_g0", obs_grant, 0);
        cycle();
        check("t4_g1", obs_grant, 2);
        cycle();
        check("t4_g2", obs_grant, 0);

        // 5: clear pulse in the middle of traffic
        valid = 4'hF;
        for (int k = 0; k < 3; k++) cycle();
        clear_start = 1'b1;
        cycle();
        g = obs_grant;
        check("t5_pulse_we", {31'd0, we}, 1);
        clear_start = 1'b0;
        for (int i = 0; i < NR; i++) begin
            cycle();
            check("t5_no_grant", obs_grant, -1);
        end
        cycle();
        check("t5_resume", obs_grant, (g + 1) % NQ);

        // 6: reset in the middle of a clear
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 100; i++) cycle();
        rst_n = 1'b0;
        #1;
        check("t6_we_drop", {31'd0, we}, 0);
        check("t6_busy", {31'd0, busy}, 1);
        check("t6_ready", {28'd0, ready}, 0);
        model_reset();
        #4;
        rst_n = 1'b1;
        cycle();
        check("t6_restart", {23'd0, we, waddr}, {23'd0, 1'b1, 8'h00});
        for (int i = 1; i < NR; i++) cycle();
        check("t6_done", {31'd0, busy}, 0);

        // random traffic with occasional clear pulses
        for (int n = 0; n < 400; n++) begin
            valid = 4'($urandom);
            addr = $urandom;
            data = $urandom;
            clear_start = ($urandom_range(0, 79) == 0);
            cycle();
        end
        clear_start = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
